// File: rtl/broadcast_queue.sv
// Result broadcast queue: accepts up to NUM_FU results per cycle into a FIFO
// and drains one result per cycle onto the common data bus.
module broadcast_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 7,
    parameter int NUM_FU     = 4,
    parameter int DEPTH      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [NUM_FU-1:0]            fu_done,
    input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
    input  logic [NUM_FU*DATA_WIDTH-1:0] fu_result,
    output logic [NUM_FU-1:0]            fu_queued,
    output logic                         cdb_valid,
    output logic [TAG_WIDTH-1:0]         cdb_tag,
    output logic [DATA_WIDTH-1:0]        cdb_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [TAG_WIDTH-1:0]  r_tag_mem  [DEPTH];
    logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_cdb_valid;
    logic [TAG_WIDTH-1:0]  r_cdb_tag;
    logic [DATA_WIDTH-1:0] r_cdb_data;

    logic [CW-1:0]         w_free;
    logic [CW-1:0]         w_gcnt;
    logic [NUM_FU-1:0]     w_queued;
    logic [AW-1:0]         w_slot [NUM_FU];
    logic                  w_pop;

    // Space is judged on registered occupancy only, so grants never depend on the drain.
    assign w_free = DEPTH_C - r_count;
    assign w_pop  = (r_count != '0) && !flush;

    always_comb begin
        logic [CW-1:0] acc;
        acc      = '0;
        w_queued = '0;
        for (int i = 0; i < NUM_FU; i++) begin
            w_slot[i] = r_wr_ptr + acc[AW-1:0];
            if (fu_done[i] && !flush && rst && (acc < w_free)) begin
                w_queued[i] = 1'b1;
                acc         = acc + 1'b1;
            end
        end
        w_gcnt = acc;
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_FU; i++) begin
            if (w_queued[i]) begin
                r_tag_mem[w_slot[i]]  <= fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
                r_data_mem[w_slot[i]] <= fu_result[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cdb_valid <= 1'b0;
            r_cdb_tag   <= '0;
            r_cdb_data  <= '0;
        end else if (flush) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cdb_valid <= 1'b0;
        end else begin
            r_wr_ptr    <= r_wr_ptr + w_gcnt[AW-1:0];
            r_rd_ptr    <= r_rd_ptr + AW'(w_pop);
            r_count     <= r_count + w_gcnt - CW'(w_pop);
            r_cdb_valid <= w_pop;
            if (w_pop) begin
                r_cdb_tag  <= r_tag_mem[r_rd_ptr];
                r_cdb_data <= r_data_mem[r_rd_ptr];
            end
        end
    end

    assign fu_queued = w_queued;
    assign cdb_valid = r_cdb_valid;
    assign cdb_tag   = r_cdb_tag;
    assign cdb_data  = r_cdb_data;
    assign count     = r_count;
    assign full      = (r_count == DEPTH_C);
    assign empty     = (r_count == '0);

endmodule
